// File: rtl/fpu.sv
// -----------------------------------------------------------------------------
// fpu -- multi-cycle adder for a custom 32-bit floating-point format.
//
// Number format (both operands and the result):
//   [31]    sign
//   [30:25] exponent E, bias 31; E == 0 is flushed to zero whatever M holds
//   [24:0]  mantissa M; value = (-1)^s * 1.M * 2^(E-31)
//
// The block runs a free-running FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND ->
// DONE -> IDLE. Operands are captured only in IDLE. The result and its status
// are loaded together in DONE and held until the next DONE.
//
// Ports:
//   clock100KHz  in   1   sole clock, rising edge
//   reset        in   1   synchronous, active-high; aborts any operation
//   op_A_in      in  32   operand A
//   op_B_in      in  32   operand B
//   data_out     out 32   registered sum A+B
//   status_out   out  4   one-hot: [0] EXACT [1] OVERFLOW [2] UNDERFLOW [3] INEXACT
//
// Configuration macro:
//   FPU_ROUND_EN  defined   -> ROUND applies round-to-nearest, ties-to-even
//                 undefined -> ROUND truncates; INEXACT still reports lost bits
// -----------------------------------------------------------------------------
module fpu (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic [31:0] op_A_in,
  input  logic [31:0] op_B_in,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state_reg, state_next;

  // Working significand layout (30 bits):
  //   [29] carry out of the add, [28] hidden bit, [27:3] fraction,
  //   [2] guard, [1] round, [0] sticky.
  // Keeping a round bit lets a single post-subtraction left shift still leave
  // a correct guard bit; rounding folds round and sticky together.
  logic [31:0] op_word [2];
  logic        op_sign [2];
  logic [5:0]  op_exp  [2];
  logic [29:0] op_mant [2];

  assign op_word[0] = op_A_in;
  assign op_word[1] = op_B_in;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign op_sign[gi] = op_word[gi][31];
      assign op_exp[gi]  = op_word[gi][30:25];
      // Flush-to-zero: a zero exponent yields a zero significand.
      assign op_mant[gi] = (op_exp[gi] == 6'd0) ? 30'd0
                                                : {2'b01, op_word[gi][24:0], 3'b000};
    end
  endgenerate

  // The larger-exponent operand always goes to the "big" slot so that only the
  // small slot ever needs shifting.
  logic a_is_big;
  assign a_is_big = (op_exp[0] >= op_exp[1]);

  logic               big_sign_reg, small_sign_reg, res_sign_reg;
  logic [29:0]        big_m_reg, small_m_reg, m_reg;
  logic signed [7:0]  exp_reg;
  logic [5:0]         diff_reg;
  logic [31:0]        result_reg;
  logic [3:0]         rstat_reg;

  // One-bit right shift that folds everything leaving the bottom into sticky.
  logic [29:0] small_shifted;
  assign small_shifted = {1'b0, small_m_reg[29:2], small_m_reg[1] | small_m_reg[0]};

  // Magnitude add / subtract; sign follows the larger magnitude, exact
  // cancellation is forced positive.
  logic [29:0] add_sum;
  logic        add_sign;

  always_comb begin
    add_sum  = 30'd0;
    add_sign = 1'b0;
    if (big_sign_reg == small_sign_reg) begin
      add_sum  = big_m_reg + small_m_reg;
      add_sign = big_sign_reg;
    end else if (big_m_reg >= small_m_reg) begin
      add_sum  = big_m_reg - small_m_reg;
      add_sign = (big_m_reg == small_m_reg) ? 1'b0 : big_sign_reg;
    end else begin
      add_sum  = small_m_reg - big_m_reg;
      add_sign = small_sign_reg;
    end
  end

  logic norm_done;
  assign norm_done = m_reg[29] | m_reg[28] | (m_reg == 30'd0);

  // Rounding and final classification of the normalised significand.
  logic              guard_bit, sticky_bit, inexact, round_up;
  logic [25:0]       frac_inc;
  logic [24:0]       mant_fin;
  logic signed [7:0] exp_fin;
  logic [31:0]       result_next;
  logic [3:0]        rstat_next;

  always_comb begin
    guard_bit  = m_reg[2];
    sticky_bit = m_reg[1] | m_reg[0];
    inexact    = guard_bit | sticky_bit;
`ifdef FPU_ROUND_EN
    round_up   = guard_bit & (sticky_bit | m_reg[3]);
`else
    round_up   = 1'b0;
`endif
    // A carry out of the fraction means 1.111..1 rounded up to 10.000..0:
    // renormalise by bumping the exponent with a zero fraction.
    frac_inc   = {1'b0, m_reg[27:3]} + {25'd0, round_up};
    mant_fin   = frac_inc[25] ? 25'd0 : frac_inc[24:0];
    exp_fin    = exp_reg + (frac_inc[25] ? 8'sd1 : 8'sd0);

    result_next = 32'd0;
    rstat_next  = 4'b0001;
    if (m_reg == 30'd0) begin
      result_next = 32'd0;
      rstat_next  = 4'b0001;
    end else if (exp_fin > 8'sd63) begin
      result_next = {res_sign_reg, 6'd63, 25'd0};
      rstat_next  = 4'b0010;
    end else if (exp_fin < 8'sd1) begin
      result_next = 32'd0;
      rstat_next  = 4'b0100;
    end else begin
      result_next = {res_sign_reg, exp_fin[5:0], mant_fin};
      rstat_next  = inexact ? 4'b1000 : 4'b0001;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  state_next = ALIGN;
      // Differences above 27 push every significand bit past the round bit,
      // so the small operand collapses to sticky in a single step.
      ALIGN: if (diff_reg == 6'd0 || diff_reg > 6'd27) state_next = ADD;
      ADD:   state_next = NORM;
      NORM:  if (norm_done) state_next = ROUND;
      ROUND: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state_reg      <= IDLE;
      data_out       <= 32'd0;
      status_out     <= 4'b0000;
      big_sign_reg   <= 1'b0;
      small_sign_reg <= 1'b0;
      res_sign_reg   <= 1'b0;
      big_m_reg      <= 30'd0;
      small_m_reg    <= 30'd0;
      m_reg          <= 30'd0;
      exp_reg        <= 8'sd0;
      diff_reg       <= 6'd0;
      result_reg     <= 32'd0;
      rstat_reg      <= 4'b0000;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (a_is_big) begin
            big_sign_reg   <= op_sign[0];
            big_m_reg      <= op_mant[0];
            small_sign_reg <= op_sign[1];
            small_m_reg    <= op_mant[1];
            exp_reg        <= $signed({2'b00, op_exp[0]});
            diff_reg       <= op_exp[0] - op_exp[1];
          end else begin
            big_sign_reg   <= op_sign[1];
            big_m_reg      <= op_mant[1];
            small_sign_reg <= op_sign[0];
            small_m_reg    <= op_mant[0];
            exp_reg        <= $signed({2'b00, op_exp[1]});
            diff_reg       <= op_exp[1] - op_exp[0];
          end
        end
        ALIGN: begin
          if (diff_reg > 6'd27) begin
            small_m_reg <= {29'd0, |small_m_reg};
          end else if (diff_reg != 6'd0) begin
            small_m_reg <= small_shifted;
            diff_reg    <= diff_reg - 6'd1;
          end
        end
        ADD: begin
          m_reg        <= add_sum;
          res_sign_reg <= add_sign;
        end
        NORM: begin
          if (m_reg[29]) begin
            m_reg   <= {1'b0, m_reg[29:2], m_reg[1] | m_reg[0]};
            exp_reg <= exp_reg + 8'sd1;
          end else if (!m_reg[28] && m_reg != 30'd0) begin
            m_reg   <= {m_reg[28:0], 1'b0};
            exp_reg <= exp_reg - 8'sd1;
          end
        end
        ROUND: begin
          result_reg <= result_next;
          rstat_reg  <= rstat_next;
        end
        DONE: begin
          data_out   <= result_reg;
          status_out <= rstat_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu.sv
// -----------------------------------------------------------------------------
// tb_fpu -- directed-vector bench for fpu. Each vector holds the operands under
// reset, releases reset, waits (bounded) for the first DONE result and compares
// data, status and latency against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op_a, op_b;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int n_checks = 0;
  int n_fail   = 0;

  fpu dut (
    .clock100KHz (clk),
    .reset       (reset),
    .op_A_in     (op_a),
    .op_B_in     (op_b),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fp(input logic s, input logic [5:0] e, input logic [24:0] m);
    return {s, e, m};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Waits for the first loaded result after a reset release (status becomes
  // one-hot nonzero) and checks it; cyc counts edges since release.
  task automatic wait_result(input string tag, input logic [31:0] exp_d, input logic [3:0] exp_s,
                             input bit poke);
    int cyc;
    @(negedge clk);
    cyc = 1;
    if (poke) begin
      // Already captured: these must be ignored until the next IDLE.
      op_a = 32'h1234_5678;
      op_b = 32'h8ABC_DEF0;
    end
    while (status_out == 4'b0000 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    $display("%-14s data=%h status=%b latency=%0d", tag, data_out, status_out, cyc);
    check({tag, ".data"},   data_out,            exp_d);
    check({tag, ".status"}, {28'd0, status_out}, {28'd0, exp_s});
    check({tag, ".lat"},    {31'd0, cyc <= 64},  32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic [3:0] exp_s, input bit poke);
    @(negedge clk);
    reset = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_result(tag, exp_d, exp_s, poke);
  endtask

  initial begin
    reset = 1'b1;
    op_a  = 32'd0;
    op_b  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset.data",   data_out,            32'd0);
    check("reset.status", {28'd0, status_out}, 32'd0);

    run_vec("zero+zero",  32'd0, 32'd0, 32'd0, 4'b0001, 1'b0);
    run_vec("one+one",    fp(0,31,0), fp(0,31,0), 32'h4000_0000, 4'b0001, 1'b1);
    run_vec("one-one",    fp(0,31,0), fp(1,31,0), 32'd0, 4'b0001, 1'b0);
    run_vec("far_shift",  fp(0,50,100), fp(0,10,100), fp(0,50,100), 4'b1000, 1'b0);
    run_vec("overflow",   fp(0,63,25'h1FFFFFF), fp(0,63,25'h1FFFFFF), 32'h7E00_0000, 4'b0010, 1'b0);
    run_vec("underflow",  fp(0,1,1), fp(1,1,0), 32'd0, 4'b0100, 1'b0);
    run_vec("neg_sum",    fp(1,32,0), fp(1,32,0), 32'hC200_0000, 4'b0001, 1'b0);
    run_vec("mixed_sign", fp(1,31,0), fp(0,30,0), 32'hBC00_0000, 4'b0001, 1'b0);
    run_vec("mant_carry", fp(0,31,25'h1FFFFFF), fp(0,6,0), 32'h4000_0000, 4'b0001, 1'b0);
`ifdef FPU_ROUND_EN
    run_vec("tie_odd",     fp(0,31,1), fp(0,5,0), 32'h3E00_0002, 4'b1000, 1'b0);
    run_vec("round_carry", fp(0,31,25'h1FFFFFF), fp(0,5,0), 32'h4000_0000, 4'b1000, 1'b0);
    run_vec("sub_sticky",  fp(0,31,0), fp(1,1,0), 32'h3E00_0000, 4'b1000, 1'b0);
`else
    run_vec("tie_odd",     fp(0,31,1), fp(0,5,0), 32'h3E00_0001, 4'b1000, 1'b0);
    run_vec("round_carry", fp(0,31,25'h1FFFFFF), fp(0,5,0), 32'h3FFF_FFFF, 4'b1000, 1'b0);
    run_vec("sub_sticky",  fp(0,31,0), fp(1,1,0), 32'h3DFF_FFFF, 4'b1000, 1'b0);
`endif
    run_vec("flush_zero",  fp(0,0,12345), fp(1,40,7), 32'hD000_0007, 4'b0001, 1'b0);
    run_vec("neg_overflow", fp(1,63,0), fp(1,63,0), 32'hFE00_0000, 4'b0010, 1'b0);

    // Reset while outputs hold a result clears them.
    @(negedge clk);
    op_a  = fp(0,40,0);
    op_b  = fp(0,20,0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_hold.data",   data_out,            32'd0);
    check("rst_hold.status", {28'd0, status_out}, 32'd0);
    // Release, let the 20-step alignment get under way, then abort it.
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    op_a  = fp(0,33,5);
    op_b  = fp(0,33,3);
    @(negedge clk);
    check("rst_align.data",   data_out,            32'd0);
    check("rst_align.status", {28'd0, status_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_result("after_abort", 32'h4400_0004, 4'b0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
